// File: rtl/info_packer_pkg.sv
// rtl/info_packer_pkg.sv - packer-local state type and lane index width
package info_packer_pkg;
  import template_pkg::*;

  typedef enum logic {FILL, GAP} packer_state_e;

  localparam int LANE_WIDTH = (LANES > 1) ? $clog2(LANES) : 1;
endpackage

// File: rtl/template_pkg.sv
// rtl/template_pkg.sv - beat geometry and payload type shared by the packer and the beat counter
package template_pkg;
  localparam int LANES      = 2;
  localparam int ADDR_WIDTH = 8;
  localparam int CNT_WIDTH  = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_END = 4'd15;

  typedef struct packed {
    logic [LANES-1:0]                 vld;
    logic [LANES-1:0][ADDR_WIDTH-1:0] addr;
  } info_t;
endpackage

// File: rtl/info_packer_if.sv
// rtl/info_packer_if.sv - request, flush, beat and frame signals between packer and its neighbours
interface info_packer_if;
  import template_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  flush;
  logic                  end_cnt;
  logic                  flag_cnt;
  info_t                 info;
  logic                  busy;

  modport master (
    output req_valid, req_addr, flush, end_cnt,
    input  req_ready, flag_cnt, info, busy
  );

  modport slave (
    input  req_valid, req_addr, flush, end_cnt,
    output req_ready, flag_cnt, info, busy
  );
endinterface

// File: rtl/info_packer_gap_timer.sv
// rtl/info_packer_gap_timer.sv - loadable down-counter with done flag (gap and idle timeout)
module packer_gap_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);
endmodule

// File: rtl/info_packer.sv
// rtl/info_packer.sv - packs single-address requests into info_t beats with an inter-frame gap
// Optional idle auto-flush of partial beats: INFO_PACKER_TIMEOUT_EN.
module info_packer
  import template_pkg::*;
  import info_packer_pkg::*;
#(
  parameter int GAP_CYCLES = 3,
  parameter int TIMEOUT    = 8
) (
  input  logic         clk,
  input  logic         rst,
  info_packer_if.slave bus
);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  packer_state_e         state, state_nxt;
  info_t                 staging, stage_nxt, info_q;
  logic [LANE_WIDTH-1:0] lane;
  logic                  flag_q, ready_q, pending_flush;
  logic                  accept, staged_any, full, emit;
  logic                  gap_start, gap_done, timeout_flush;

  assign accept     = bus.req_valid & ready_q;
  assign staged_any = |staging.vld;
  assign full       = accept && (lane == LANE_WIDTH'(LANES - 1));
  assign gap_start  = (state == FILL) && bus.end_cnt && (GAP_CYCLES > 0);

  // Partial emits only happen in FILL; a flush seen during GAP is replayed via pending_flush.
  assign emit = full || ((state == FILL) &&
                ((bus.flush && (staged_any || accept)) ||
                 (pending_flush && staged_any) || timeout_flush));

  always_comb begin
    stage_nxt = staging;
    if (accept) begin
      stage_nxt.vld[lane]  = 1'b1;
      stage_nxt.addr[lane] = bus.req_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (gap_start) state_nxt = GAP;
      GAP:     if (gap_done)  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  packer_gap_timer #(.WIDTH(GW)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_start),
    .load_val (GW'(GAP_CYCLES - 1)),
    .en       (state == GAP),
    .done     (gap_done)
  );

`ifdef INFO_PACKER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic timeout_done, idle_staged;

  assign idle_staged = (state == FILL) && staged_any && !accept;

  packer_gap_timer #(.WIDTH(TW)) u_timeout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || emit),
    .load_val (TW'(TIMEOUT - 1)),
    .en       (idle_staged),
    .done     (timeout_done)
  );

  assign timeout_flush = idle_staged && timeout_done;
`else
  assign timeout_flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      ready_q       <= 1'b0;
      flag_q        <= 1'b0;
      info_q        <= '0;
      staging       <= '0;
      lane          <= '0;
      pending_flush <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == FILL);
      flag_q  <= emit;
      if (emit) begin
        info_q  <= stage_nxt;
        staging <= '0;
        lane    <= '0;
      end else begin
        staging <= stage_nxt;
        if (accept) lane <= lane + 1'b1;
      end
      if (state == GAP && bus.flush) pending_flush <= 1'b1;
      else if (state == FILL)        pending_flush <= 1'b0;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.flag_cnt  = flag_q;
  assign bus.info      = info_q;
  assign bus.busy      = staged_any || (state == GAP);
endmodule

// File: tb/tb_info_packer.sv
// tb/tb_info_packer.sv - table-driven and sequence checks for info_packer (LANES=2, GAP_CYCLES=3, TIMEOUT=8)
module tb_info_packer;
  import template_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  info_packer_if bus ();

  info_packer #(.GAP_CYCLES(3), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] addr;
    logic       flush;
    logic       end_cnt;
    logic       flag;
    logic [1:0] vld;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       ready;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [7:0] ad, input logic fl, input logic ec,
                              input logic f, input logic [1:0] vl, input logic [7:0] x0,
                              input logic [7:0] x1, input logic r, input logic b);
    vec_t t;
    t.valid = v; t.addr = ad; t.flush = fl; t.end_cnt = ec;
    t.flag = f; t.vld = vl; t.a0 = x0; t.a1 = x1; t.ready = r; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] ad, input logic fl, input logic ec);
    bus.req_valid = v;
    bus.req_addr  = ad;
    bus.flush     = fl;
    bus.end_cnt   = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string name, input logic [1:0] vl, input logic [7:0] x0,
                            input logic [7:0] x1);
    check({name, " flag"}, 32'(bus.flag_cnt), 32'd1);
    check({name, " vld"},  32'(bus.info.vld), 32'(vl));
    check({name, " a0"},   32'(bus.info.addr[0]), 32'(x0));
    check({name, " a1"},   32'(bus.info.addr[1]), 32'(x1));
  endtask

  initial begin
    int n;
    logic seen;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.end_cnt   = 1'b0;

    // Reset held for two cycles, then released.
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("reset flag",  32'(bus.flag_cnt),  32'd0);
    check("reset info",  32'(bus.info),      32'd0);
    check("reset ready", 32'(bus.req_ready), 32'd0);
    check("reset busy",  32'(bus.busy),      32'd0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    check("release ready", 32'(bus.req_ready), 32'd1);

    // valid addr flush end_cnt | flag vld a0 a1 ready busy (outputs after the edge)
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 2'b00, 8'h00, 8'h00, 1, 1));
    vecs.push_back(mk(1, 8'h02, 0, 0, 1, 2'b11, 8'h01, 8'h02, 1, 0));
    vecs.push_back(mk(1, 8'h03, 0, 0, 0, 2'b11, 8'h01, 8'h02, 1, 1));
    vecs.push_back(mk(1, 8'h04, 0, 0, 1, 2'b11, 8'h03, 8'h04, 1, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0, 0, 2'b11, 8'h03, 8'h04, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2'b11, 8'h03, 8'h04, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 2'b01, 8'h05, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 2'b01, 8'h05, 8'h00, 1, 0));
    vecs.push_back(mk(1, 8'h0a, 0, 0, 0, 2'b01, 8'h05, 8'h00, 1, 1));
    vecs.push_back(mk(1, 8'h0b, 0, 0, 1, 2'b11, 8'h0a, 8'h0b, 1, 0));
    vecs.push_back(mk(1, 8'h06, 0, 1, 0, 2'b11, 8'h0a, 8'h0b, 0, 1));
    vecs.push_back(mk(1, 8'h33, 1, 0, 0, 2'b11, 8'h0a, 8'h0b, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 2'b11, 8'h0a, 8'h0b, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2'b11, 8'h0a, 8'h0b, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 2'b01, 8'h06, 8'h00, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].valid, vecs[i].addr, vecs[i].flush, vecs[i].end_cnt);
      check($sformatf("row%0d flag", i),  32'(bus.flag_cnt),     32'(vecs[i].flag));
      check($sformatf("row%0d vld", i),   32'(bus.info.vld),     32'(vecs[i].vld));
      check($sformatf("row%0d a0", i),    32'(bus.info.addr[0]), 32'(vecs[i].a0));
      check($sformatf("row%0d a1", i),    32'(bus.info.addr[1]), 32'(vecs[i].a1));
      check($sformatf("row%0d ready", i), 32'(bus.req_ready),    32'(vecs[i].ready));
      check($sformatf("row%0d busy", i),  32'(bus.busy),         32'(vecs[i].busy));
    end

    // Lone request left idle: auto-flush after 8 idle cycles only when the timeout is built in.
    step(1, 8'h07, 0, 0);
    check("idle accept flag", 32'(bus.flag_cnt), 32'd0);
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 50 && !seen; k++) begin
      step(0, 0, 0, 0);
      if (bus.flag_cnt) begin
        seen = 1'b1;
        n = k;
      end
    end
`ifdef INFO_PACKER_TIMEOUT_EN
    check("timeout seen", 32'(seen), 32'd1);
    check("timeout idle cycles", 32'(n), 32'd8);
    check("timeout vld", 32'(bus.info.vld), 32'd1);
    check("timeout a0",  32'(bus.info.addr[0]), 32'h07);
`else
    check("no timeout pulse", 32'(seen), 32'd0);
    check("still busy", 32'(bus.busy), 32'd1);
    step(0, 0, 1, 0);
    check_beat("manual flush", 2'b01, 8'h07, 8'h00);
`endif

    // Reset mid-fill drops the staged lane; refill starts again at lane 0.
    step(1, 8'h09, 0, 0);
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    check("midfill rst flag", 32'(bus.flag_cnt), 32'd0);
    check("midfill rst busy", 32'(bus.busy), 32'd0);
    check("midfill rst info", 32'(bus.info), 32'd0);
    step(0, 0, 0, 0);
    check("midfill rst flag2", 32'(bus.flag_cnt), 32'd0);
    check("midfill ready", 32'(bus.req_ready), 32'd1);
    step(1, 8'h21, 0, 0);
    check("refill lane0 flag", 32'(bus.flag_cnt), 32'd0);
    step(1, 8'h22, 0, 0);
    check_beat("refill", 2'b11, 8'h21, 8'h22);
    step(0, 0, 0, 0);
    check("refill single pulse", 32'(bus.flag_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
